// File: rtl/imem_bank.sv
// imem_bank: loadable instruction memory with a single-cycle fetch port.
// A load session (EMPTY/RUN -> LOAD) streams words in at increasing word
// indices. The session returns to RUN on load_done_i or when the bank is full.
// Fetches are accepted only in RUN. Each accepted fetch is answered exactly one
// cycle later, and an error is reported for misaligned or out-of-range addresses.
// Optional feature macro: IMEM_PARITY_EN. When it is defined, each word carries
// an even-parity bit, and parity_err_o flags a parity mismatch on a fetch response.
module imem_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_start_i,
  input  logic                         load_valid_i,
  input  logic [31:0]                  load_data_i,
  input  logic                         load_done_i,
  output logic                         load_ready_o,
  output logic [$clog2(DEPTH_WORDS):0] load_count_o,
  input  logic                         fetch_req_i,
  input  logic [ADDR_WIDTH-1:0]        fetch_addr_i,
  output logic                         fetch_gnt_o,
  output logic                         fetch_rvalid_o,
  output logic [31:0]                  fetch_rdata_o,
  output logic                         fetch_err_o,
`ifdef IMEM_PARITY_EN
  output logic                         parity_err_o,
`endif
  output logic                         busy_o
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_WORDS);
`ifdef IMEM_PARITY_EN
  localparam int MW = 33;
`else
  localparam int MW = 32;
`endif

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_RUN
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ready_q, busy_q;
  logic            wr_en;
  logic [MW-1:0]   wr_word;
  logic [MW-1:0]   mem_q [DEPTH_WORDS];

  logic [ADDR_WIDTH-3:0] word_idx;
  logic                  addr_bad;
  logic [MW-1:0]         rd_word;
  logic                  rvalid_q, err_q;
  logic [31:0]           rdata_q;
`ifdef IMEM_PARITY_EN
  logic                  parity_err_q;
`endif

  // Next-state logic for the load/run controller.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    wr_en   = 1'b0;
    case (state_q)
      S_EMPTY, S_RUN: begin
        if (load_start_i) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (load_start_i) begin
          count_d = '0;
        end else begin
          if (load_valid_i && ready_q) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end
          if (load_done_i || (count_d == DEPTH_C)) begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Controller registers, with ready and busy registered from the next state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q <= S_EMPTY;
      count_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= (state_d == S_LOAD) && (count_d < DEPTH_C);
      busy_q  <= (state_d != S_RUN);
    end
  end

`ifdef IMEM_PARITY_EN
  assign wr_word = {^load_data_i, load_data_i};
`else
  assign wr_word = load_data_i;
`endif

  // Storage array. It is written sequentially while a load session is active.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents must survive rst.
    if (wr_en) begin
      mem_q[count_q[IW-1:0]] <= wr_word;
    end
  end

  assign word_idx    = fetch_addr_i[ADDR_WIDTH-1:2];
  assign addr_bad    = (fetch_addr_i[1:0] != 2'b00) ||
                       (word_idx >= (ADDR_WIDTH-2)'(DEPTH_WORDS));
  assign rd_word     = mem_q[word_idx[IW-1:0]];
  assign fetch_gnt_o = fetch_req_i && (state_q == S_RUN) && !load_start_i;

  // Fetch response stage. The data holds its value when no fetch was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
`ifdef IMEM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rvalid_q <= fetch_gnt_o;
`ifdef IMEM_PARITY_EN
      parity_err_q <= fetch_gnt_o && !addr_bad && (^rd_word);
`endif
      if (fetch_gnt_o) begin
        err_q   <= addr_bad;
        rdata_q <= addr_bad ? 32'h0 : rd_word[31:0];
      end
    end
  end

  assign load_ready_o   = ready_q;
  assign load_count_o   = count_q;
  assign busy_o         = busy_q;
  assign fetch_rvalid_o = rvalid_q;
  assign fetch_err_o    = err_q;
  assign fetch_rdata_o  = rdata_q;
`ifdef IMEM_PARITY_EN
  assign parity_err_o   = parity_err_q;
`endif

endmodule

// File: doc/imem_bank.md
IMEM_BANK -- requirements
Module: imem_bank

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit instruction words stored (power of two, min 4).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, giving the fetch byte-address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load_start_i  input  1  opens a program-load session.
REQ-006 SHALL have port load_valid_i  input  1  load_data_i holds a word.
REQ-007 SHALL have port load_data_i  input  32  instruction word to store.
REQ-008 SHALL have port load_done_i  input  1  closes the load session.
REQ-009 SHALL have port load_ready_o  output  1  bank accepts a load word this cycle.
REQ-010 SHALL have port load_count_o  output  $clog2(DEPTH_WORDS)+1  words written in the current/last session.
REQ-011 SHALL have port fetch_req_i  input  1  fetch request.
REQ-012 SHALL have port fetch_addr_i  input  ADDR_WIDTH  fetch byte address.
REQ-013 SHALL have port fetch_gnt_o  output  1  request accepted this cycle.
REQ-014 SHALL have port fetch_rvalid_o  output  1  response valid.
REQ-015 SHALL have port fetch_rdata_o  output  32  response word.
REQ-016 SHALL have port fetch_err_o  output  1  response is an error, qualified by fetch_rvalid_o.
REQ-017 SHALL have port busy_o  output  1  high when state is not RUN.

Function
REQ-018 SHALL implement FSM states EMPTY, LOAD, RUN.
REQ-019 EMPTY->LOAD on load_start_i; RUN->LOAD on load_start_i; LOAD->RUN on load_done_i or when load_count_o reaches DEPTH_WORDS.
REQ-020 On entry to LOAD (and on load_start_i while in LOAD), load_count_o SHALL clear to 0.
REQ-021 load_ready_o SHALL be 1 only in LOAD with load_count_o < DEPTH_WORDS.
REQ-022 When load_valid_i and load_ready_o, the word SHALL be written at word index load_count_o, and load_count_o SHALL increment.
REQ-023 load_valid_i with load_done_i in the same cycle SHALL write the word, then enter RUN.
REQ-024 A write of word DEPTH_WORDS-1 SHALL move the FSM to RUN next cycle; later load_valid_i SHALL be ignored.
REQ-025 fetch_gnt_o SHALL equal fetch_req_i in RUN without load_start_i, and SHALL be 0 otherwise.
REQ-026 An accepted fetch SHALL produce fetch_rvalid_o=1 exactly one cycle later, with fetch_rdata_o = word at fetch_addr_i[ADDR_WIDTH-1:2].
REQ-027 If fetch_addr_i[1:0]!=0 or word index >= DEPTH_WORDS, the response SHALL have fetch_err_o=1 and fetch_rdata_o=0.
REQ-028 Back-to-back fetches SHALL sustain one response per cycle.
REQ-029 fetch_rvalid_o SHALL be 0 in cycles with no accepted fetch on the prior cycle, and fetch_rdata_o SHALL then hold its previous value.
REQ-030 A fetch accepted in the cycle before load_start_i SHALL still receive its response.

Reset
REQ-031 rst SHALL force state EMPTY, load_count_o=0, fetch_rvalid_o=0, fetch_err_o=0, fetch_rdata_o=0, load_ready_o=0, busy_o=1.
REQ-032 rst SHALL NOT clear memory contents; a reset mid-load leaves already-written words intact.

Configuration
REQ-033 With macro IMEM_PARITY_EN defined, each word SHALL store an extra even-parity bit computed on load, and output port parity_err_o (1 bit) SHALL pulse with fetch_rvalid_o when the recomputed parity mismatches.
REQ-034 Without IMEM_PARITY_EN, no parity storage and no parity_err_o port SHALL exist; all other behaviour is identical.

Verification
REQ-035 Reset, then fetch_req_i=1 at addr 0x0 -> fetch_gnt_o=0, busy_o=1, no rvalid.
REQ-036 Load 0x00000013, 0x00100093, 0x00200113, then done; fetch 0x4 -> next cycle rvalid=1, rdata=0x00100093, err=0; load_count_o=3.
REQ-037 DEPTH_WORDS=4, load 5 words -> fifth ignored, load_ready_o=0 after the 4th word, state RUN.
REQ-038 Fetch 0x6 and 0x1000 (DEPTH_WORDS=1024) -> both responses err=1, rdata=0.
REQ-039 Assert rst after two load words, reload one word 0xDEADBEEF -> word 0 = 0xDEADBEEF, word 1 retains its prior value.
REQ-040 With IMEM_PARITY_EN, deposit an inverted parity bit at word 2 and fetch 0x8 -> parity_err_o=1 with rvalid.
